// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int UART_DEFAULT_CLK_DIV = 434;
  localparam int UART_DATA_W          = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered full/empty flags and occupancy count
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              do_push;
  logic              do_pop;

  // A push into a full FIFO is discarded even if a pop frees a slot on the same edge.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered UART 8N1 transmitter fed by unthrottled byte strobes
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV     = UART_DEFAULT_CLK_DIV,
  parameter int FIFO_ADDR_W = 4
) (
  input  logic                   sys_clk,
  input  logic                   reset_n,
  input  logic                   pause_n,
  input  logic                   wren,
  input  logic [UART_DATA_W-1:0] tx_data,
  output logic                   txd,
  output logic                   busy,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   overflow
);

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [FIFO_ADDR_W:0] DEPTH_CNT = {1'b1, {FIFO_ADDR_W{1'b0}}};

  tx_state_e              state;
  tx_state_e              state_next;
  logic [15:0]            baud_cnt;
  logic [2:0]             bit_cnt;
  logic [UART_DATA_W-1:0] shift;
  logic [UART_DATA_W-1:0] head_data;
  logic [FIFO_ADDR_W:0]   fifo_count;
  logic                   baud_done;
  logic                   pop;

  sync_fifo #(
    .DATA_W (UART_DATA_W),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .push      (wren),
    .push_data (tx_data),
    .pop       (pop),
    .pop_data  (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty && pause_n)        state_next = START;
      START:   if (baud_done)                     state_next = DATA;
      DATA:    if (baud_done && bit_cnt == 3'd7)  state_next = STOP;
      STOP:    if (baud_done)                     state_next = IDLE;
      default:                                    state_next = IDLE;
    endcase
  end

  always_comb begin
    pop  = (state == IDLE) && !fifo_empty && pause_n;
    busy = (state != IDLE);
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      txd      <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          txd      <= 1'b1;
          if (pop) begin
            shift <= head_data;
            txd   <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              txd <= 1'b1;
            end else begin
              // Look one bit ahead so txd changes exactly on the bit boundary.
              txd     <= shift[1];
              shift   <= shift >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (baud_done) baud_cnt <= '0;
          else           baud_cnt <= baud_cnt + 16'd1;
        end
        default: begin
          txd      <= 1'b1;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // Producer cannot be stalled, so a strobe into a full FIFO is only remembered.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)                             overflow <= 1'b0;
    else if (wren && fifo_count == DEPTH_CNT) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with a frame-decoding scoreboard
module tb_uart_tx_fifo;

  localparam int CD = 4;
  localparam int AW = 4;

  logic       sys_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pause_n = 1'b1;
  logic       wren    = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       txd;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

  uart_tx_fifo #(.CLK_DIV(CD), .FIFO_ADDR_W(AW)) dut (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .pause_n    (pause_n),
    .wren       (wren),
    .tx_data    (tx_data),
    .txd        (txd),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    bit         accept;
    bit         exp_full;
    bit         exp_ovf;
  } vec_t;

  vec_t       ovf_tab[17];
  logic [7:0] burst_tab[3];
  logic [7:0] sb[$];
  int         start_log[$];
  int         frames_ok = 0;
  bit         rst_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d, input bit push);
    wren    = 1'b1;
    tx_data = d;
    if (push) sb.push_back(d);
    tick();
    wren = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || !fifo_empty) && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", n < budget, 1);
    repeat (3) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  always @(negedge reset_n) rst_seen = 1'b1;

  // Decodes every frame on txd by sampling mid-bit and scores it against the queue.
  initial begin : monitor
    logic [7:0] got;
    logic       sbit;
    logic       pbit;
    int         st;
    forever begin
      @(negedge sys_clk);
      if (reset_n && txd === 1'b0) begin
        st       = cyc;
        rst_seen = 1'b0;
        repeat (CD / 2) @(negedge sys_clk);
        sbit = txd;
        for (int b = 0; b < 8; b++) begin
          repeat (CD) @(negedge sys_clk);
          got[b] = txd;
        end
        repeat (CD) @(negedge sys_clk);
        pbit = txd;
        repeat (CD / 2 - 1) @(negedge sys_clk);
        if (!rst_seen) begin
          start_log.push_back(st);
          frames_ok++;
          check("start_bit", sbit, 0);
          check("stop_bit", pbit, 1);
          check("frame_expected", sb.size() > 0, 1);
          if (sb.size() > 0) check("frame_data", got, sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, r, n0, f0, cnt, lows;

    for (int i = 0; i < 17; i++) begin
      ovf_tab[i].data     = 8'(i + 1);
      ovf_tab[i].accept   = (i < 16);
      ovf_tab[i].exp_full = (i >= 15);
      ovf_tab[i].exp_ovf  = (i == 16);
    end
    burst_tab[0] = 8'h00;
    burst_tab[1] = 8'hFF;
    burst_tab[2] = 8'h3C;

    repeat (3) tick();
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_full", fifo_full, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single byte latency, busy width and flag timing
    n0 = start_log.size();
    k  = cyc;
    strobe(8'hA5, 1'b1);
    @(negedge sys_clk);
    check("t1_empty_k1", fifo_empty, 0);
    check("t1_txd_k1", txd, 1);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge sys_clk);
      if (i == 0) begin
        check("t1_txd_k2", txd, 0);
        check("t1_empty_k2", fifo_empty, 1);
        check("t1_busy_k2", busy, 1);
      end
      if (busy) cnt++;
    end
    check("t1_busy_cycles", cnt, 40);
    wait_idle(200);
    check("t1_start_cycle", (start_log.size() > n0) ? start_log[n0] : -1, k + 2);

    // Burst of three back-to-back strobes
    n0 = start_log.size();
    f0 = frames_ok;
    k  = cyc;
    for (int i = 0; i < 3; i++) strobe(burst_tab[i], 1'b1);
    wait_idle(300);
    check("t2_frames", frames_ok - f0, 3);
    if (start_log.size() >= n0 + 3) begin
      check("t2_first_start", start_log[n0], k + 2);
      check("t2_pitch_1", start_log[n0+1] - start_log[n0], 41);
      check("t2_pitch_2", start_log[n0+2] - start_log[n0+1], 41);
    end
    check("t2_overflow", overflow, 0);

    // Overflow while paused, then drain
    f0      = frames_ok;
    pause_n = 1'b0;
    for (int i = 0; i < 17; i++) begin
      strobe(ovf_tab[i].data, ovf_tab[i].accept);
      @(negedge sys_clk);
      check($sformatf("t3_full_%0d", i), fifo_full, ovf_tab[i].exp_full);
      check($sformatf("t3_ovf_%0d", i), overflow, ovf_tab[i].exp_ovf);
    end
    check("t3_busy_paused", busy, 0);
    tick();
    pause_n = 1'b1;
    wait_idle(1000);
    check("t3_frames", frames_ok - f0, 16);
    check("t3_empty", fifo_empty, 1);
    check("t3_ovf_sticky", overflow, 1);

    // Full FIFO, pop and strobe on the same edge
    do_reset();
    check("t5_ovf_cleared", overflow, 0);
    f0      = frames_ok;
    pause_n = 1'b0;
    for (int i = 0; i < 16; i++) strobe(8'(8'h20 + i), 1'b1);
    check("t5_full_before", fifo_full, 1);
    check("t5_ovf_before", overflow, 0);
    pause_n = 1'b1;
    strobe(8'hEE, 1'b0);
    @(negedge sys_clk);
    check("t5_ovf_after", overflow, 1);
    check("t5_full_after", fifo_full, 0);
    check("t5_empty_after", fifo_empty, 0);
    check("t5_busy_after", busy, 1);
    wait_idle(1000);
    check("t5_frames", frames_ok - f0, 16);

    // Pause during DATA of the first frame with a second byte queued
    n0 = start_log.size();
    k  = cyc;
    strobe(8'h55, 1'b1);
    strobe(8'hAA, 1'b1);
    repeat (12) tick();
    pause_n = 1'b0;
    repeat (28) tick();
    lows = 0;
    cnt  = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (txd !== 1'b1) lows++;
      if (busy) cnt++;
    end
    check("t4_txd_low_while_paused", lows, 0);
    check("t4_busy_while_paused", cnt, 0);
    check("t4_one_frame_done", start_log.size() - n0, 1);
    tick();
    r       = cyc;
    pause_n = 1'b1;
    wait_idle(200);
    check("t4_frames", start_log.size() - n0, 2);
    if (start_log.size() >= n0 + 2) begin
      check("t4_first_start", start_log[n0], k + 2);
      check("t4_resume_start", start_log[n0+1], r + 1);
    end

    // Reset during bit 3 with two bytes queued
    f0 = frames_ok;
    k  = cyc;
    strobe(8'hC3, 1'b1);
    strobe(8'h11, 1'b1);
    strobe(8'h22, 1'b1);
    repeat (16) tick();
    reset_n = 1'b0;
    #1;
    check("t6_txd_in_reset", txd, 1);
    check("t6_empty_in_reset", fifo_empty, 1);
    check("t6_busy_in_reset", busy, 0);
    sb.delete();
    repeat (3) tick();
    reset_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sys_clk);
      if (txd !== 1'b1) lows++;
    end
    check("t6_quiet_after_reset", lows, 0);
    check("t6_no_frames", frames_ok - f0, 0);
    check("t6_empty_after", fifo_empty, 1);
    tick();
    strobe(8'h96, 1'b1);
    wait_idle(200);
    check("t6_new_frame", frames_ok - f0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
